// File: rtl/rs_alloc_tracker_pkg.sv
// Shared reservation-station constants: default geometry and RS type codes.
package rs_alloc_tracker_pkg;

    localparam int RS_ENT_NUM = 8;
    localparam int RS_ENT_SEL = 3;

    typedef enum logic [2:0] {
        RS_ALU    = 3'd0,
        RS_BRANCH = 3'd1,
        RS_MUL    = 3'd2,
        RS_LDST   = 3'd3,
        RS_C1     = 3'd4,
        RS_C2     = 3'd5
    } rs_type_e;

endpackage

// File: rtl/rs_freefinder.sv
// Finds the lowest and second-lowest free entries of a busy vector.
module rs_freefinder #(
    parameter int ENT_NUM = 8,
    parameter int ENT_SEL = 3
) (
    input  logic [ENT_NUM-1:0] busy,
    output logic [ENT_SEL-1:0] f0,
    output logic [ENT_SEL-1:0] f1,
    output logic               f0_valid,
    output logic               f1_valid
);

    always_comb begin
        f0       = '0;
        f1       = '0;
        f0_valid = 1'b0;
        f1_valid = 1'b0;
        for (int i = 0; i < ENT_NUM; i++) begin
            if (!busy[i]) begin
                if (!f0_valid) begin
                    f0       = ENT_SEL'(i);
                    f0_valid = 1'b1;
                end else if (!f1_valid) begin
                    f1       = ENT_SEL'(i);
                    f1_valid = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/rs_alloc_tracker.sv
// Tracks busy entries of one reservation station and hands out up to
// two free entry indices per cycle to the dispatch slots.
module rs_alloc_tracker
    import rs_alloc_tracker_pkg::*;
#(
    parameter int ENT_NUM = RS_ENT_NUM,
    parameter int ENT_SEL = RS_ENT_SEL
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               req1,
    input  logic               req2,
    input  logic [1:0]         reqnum,
    input  logic               stall_dp,
    input  logic               flush,
    input  logic               clr1_valid,
    input  logic [ENT_SEL-1:0] clr1_ent,
    input  logic               clr2_valid,
    input  logic [ENT_SEL-1:0] clr2_ent,
    output logic               allocatable,
    output logic [ENT_SEL-1:0] ent1,
    output logic [ENT_SEL-1:0] ent2,
    output logic [ENT_NUM-1:0] busyvec,
    output logic [ENT_SEL:0]   free_cnt
);

    logic [ENT_NUM-1:0] r_busy;
    logic [ENT_SEL:0]   r_free;

    logic [ENT_SEL-1:0] w_f0;
    logic [ENT_SEL-1:0] w_f1;
    logic               w_f0_v;
    logic               w_f1_v;
    logic               w_alloc_ok;
    logic               w_commit;
    logic               w_ent2_v;
    logic [ENT_SEL-1:0] w_ent2;
    logic [ENT_NUM-1:0] w_alloc_mask;
    logic [ENT_NUM-1:0] w_clr_mask;
    logic [ENT_NUM-1:0] w_rel_mask;
    logic [ENT_NUM-1:0] w_busy_nxt;
    logic [ENT_SEL:0]   w_alloc_cnt;
    logic [ENT_SEL:0]   w_rel_cnt;
    logic [ENT_SEL:0]   w_free_nxt;
    logic [ENT_SEL:0]   w_zero_cnt;

    rs_freefinder #(
        .ENT_NUM (ENT_NUM),
        .ENT_SEL (ENT_SEL)
    ) u_find (
        .busy     (r_busy),
        .f0       (w_f0),
        .f1       (w_f1),
        .f0_valid (w_f0_v),
        .f1_valid (w_f1_v)
    );

    // Slot 2 takes the second free entry only when slot 1 also requests.
    assign w_ent2      = req1 ? w_f1 : w_f0;
    assign w_ent2_v    = req1 ? w_f1_v : w_f0_v;
    assign w_alloc_ok  = ({{(ENT_SEL-1){1'b0}}, reqnum} <= r_free);
    assign w_commit    = w_alloc_ok & ~stall_dp & ~flush;
    assign allocatable = w_alloc_ok;
    assign ent1        = w_f0;
    assign ent2        = w_ent2;
    assign busyvec     = r_busy;
    assign free_cnt    = r_free;

    always_comb begin
        w_alloc_mask = '0;
        w_clr_mask   = '0;
        if (w_commit && req1 && w_f0_v) w_alloc_mask[w_f0] = 1'b1;
        if (w_commit && req2 && w_ent2_v) w_alloc_mask[w_ent2] = 1'b1;
        if (clr1_valid) w_clr_mask[clr1_ent] = 1'b1;
        if (clr2_valid) w_clr_mask[clr2_ent] = 1'b1;
    end

    // Only busy entries count as released, so double or stale clears are free.
    assign w_rel_mask = r_busy & w_clr_mask;
    assign w_busy_nxt = (r_busy & ~w_clr_mask) | w_alloc_mask;

    always_comb begin
        w_alloc_cnt = '0;
        w_rel_cnt   = '0;
        w_zero_cnt  = '0;
        for (int i = 0; i < ENT_NUM; i++) begin
            w_alloc_cnt = w_alloc_cnt + (ENT_SEL+1)'(w_alloc_mask[i]);
            w_rel_cnt   = w_rel_cnt + (ENT_SEL+1)'(w_rel_mask[i]);
            w_zero_cnt  = w_zero_cnt + (ENT_SEL+1)'(!r_busy[i]);
        end
    end

    assign w_free_nxt = r_free - w_alloc_cnt + w_rel_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_busy <= '0;
            r_free <= (ENT_SEL+1)'(ENT_NUM);
        end else if (flush) begin
            r_busy <= '0;
            r_free <= (ENT_SEL+1)'(ENT_NUM);
        end else begin
            r_busy <= w_busy_nxt;
            r_free <= w_free_nxt;
        end
    end

    a_free_matches_busy : assert property (
        @(posedge clk) disable iff (reset) r_free == w_zero_cnt
    );

endmodule

// File: tb/tb_rs_alloc_tracker.sv
// Directed bench for rs_alloc_tracker with hand-computed expectations.
module tb_rs_alloc_tracker;

    logic       clk;
    logic       reset;
    logic       req1;
    logic       req2;
    logic [1:0] reqnum;
    logic       stall_dp;
    logic       flush;
    logic       clr1_valid;
    logic [2:0] clr1_ent;
    logic       clr2_valid;
    logic [2:0] clr2_ent;
    logic       allocatable;
    logic [2:0] ent1;
    logic [2:0] ent2;
    logic [7:0] busyvec;
    logic [3:0] free_cnt;

    int n_cmp;
    int n_bad;

    rs_alloc_tracker #(.ENT_NUM(8), .ENT_SEL(3)) dut (
        .clk         (clk),
        .reset       (reset),
        .req1        (req1),
        .req2        (req2),
        .reqnum      (reqnum),
        .stall_dp    (stall_dp),
        .flush       (flush),
        .clr1_valid  (clr1_valid),
        .clr1_ent    (clr1_ent),
        .clr2_valid  (clr2_valid),
        .clr2_ent    (clr2_ent),
        .allocatable (allocatable),
        .ent1        (ent1),
        .ent2        (ent2),
        .busyvec     (busyvec),
        .free_cnt    (free_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drv(input logic r1, input logic r2, input logic [1:0] rn,
                       input logic st, input logic fl,
                       input logic c1v, input logic [2:0] c1e,
                       input logic c2v, input logic [2:0] c2e);
        req1 = r1; req2 = r2; reqnum = rn; stall_dp = st; flush = fl;
        clr1_valid = c1v; clr1_ent = c1e; clr2_valid = c2v; clr2_ent = c2e;
        #1;
    endtask

    task automatic idle();
        drv(0, 0, 2'd0, 0, 0, 0, 3'd0, 0, 3'd0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic state(input string tag, input logic [7:0] b,
                         input logic [3:0] f);
        chk({tag, ".busy"}, 32'(busyvec), 32'(b));
        chk({tag, ".free"}, 32'(free_cnt), 32'(f));
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        reset = 1'b1;
        idle();
        state("rst", 8'h00, 4'd8);
        chk("rst.alloc", 32'(allocatable), 32'd1);
        step();
        reset = 1'b0;
        step();

        // pair allocation from empty
        drv(1, 1, 2'd2, 0, 0, 0, 3'd0, 0, 3'd0);
        chk("pair.alloc", 32'(allocatable), 32'd1);
        chk("pair.ent1", 32'(ent1), 32'd0);
        chk("pair.ent2", 32'(ent2), 32'd1);
        step();
        state("pair", 8'h03, 4'd6);

        // build 8'h05
        drv(0, 0, 2'd0, 0, 0, 1, 3'd1, 0, 3'd0);
        step();
        drv(1, 1, 2'd2, 0, 0, 0, 3'd0, 0, 3'd0);
        step();
        drv(0, 0, 2'd0, 0, 0, 1, 3'd1, 0, 3'd0);
        step();
        state("b05", 8'h05, 4'd6);

        // slot 2 alone takes lowest free
        drv(0, 1, 2'd1, 0, 0, 0, 3'd0, 0, 3'd0);
        chk("s2.ent2", 32'(ent2), 32'd1);
        step();
        state("s2", 8'h07, 4'd5);

        // fill to 8'h7F
        drv(1, 1, 2'd2, 0, 0, 0, 3'd0, 0, 3'd0);
        step();
        drv(1, 1, 2'd2, 0, 0, 0, 3'd0, 0, 3'd0);
        step();
        state("b7f", 8'h7F, 4'd1);

        // one free, two requested: nothing commits
        drv(1, 1, 2'd2, 0, 0, 0, 3'd0, 0, 3'd0);
        chk("one2.alloc", 32'(allocatable), 32'd0);
        step();
        state("one2", 8'h7F, 4'd1);

        // stall holds the allocation
        drv(1, 0, 2'd1, 1, 0, 0, 3'd0, 0, 3'd0);
        chk("stall.alloc", 32'(allocatable), 32'd1);
        step();
        state("stall", 8'h7F, 4'd1);

        drv(1, 0, 2'd1, 0, 0, 0, 3'd0, 0, 3'd0);
        chk("one1.alloc", 32'(allocatable), 32'd1);
        chk("one1.ent1", 32'(ent1), 32'd7);
        step();
        state("full", 8'hFF, 4'd0);

        // full; a same-cycle clear is not yet usable
        drv(1, 0, 2'd1, 0, 0, 1, 3'd3, 0, 3'd0);
        chk("full.alloc", 32'(allocatable), 32'd0);
        step();
        drv(1, 0, 2'd1, 0, 0, 0, 3'd0, 0, 3'd0);
        state("clr3", 8'hF7, 4'd1);
        chk("clr3.alloc", 32'(allocatable), 32'd1);
        chk("clr3.ent1", 32'(ent1), 32'd3);
        idle();

        // flush and rebuild 8'h0F
        drv(0, 0, 2'd0, 0, 1, 0, 3'd0, 0, 3'd0);
        step();
        state("fl1", 8'h00, 4'd8);
        drv(1, 1, 2'd2, 0, 0, 0, 3'd0, 0, 3'd0);
        step();
        step();
        state("b0f", 8'h0F, 4'd4);

        // double clear of entry 2 with a pair allocation
        drv(1, 1, 2'd2, 0, 0, 1, 3'd2, 1, 3'd2);
        chk("dbl.ent1", 32'(ent1), 32'd4);
        chk("dbl.ent2", 32'(ent2), 32'd5);
        step();
        state("dbl", 8'h3B, 4'd3);

        // clearing a free entry is a no-op
        drv(0, 0, 2'd0, 0, 0, 1, 3'd7, 0, 3'd0);
        step();
        state("noop", 8'h3B, 4'd3);

        // build 8'hAA
        drv(0, 0, 2'd0, 0, 1, 0, 3'd0, 0, 3'd0);
        step();
        drv(1, 1, 2'd2, 0, 0, 0, 3'd0, 0, 3'd0);
        step();
        step();
        step();
        step();
        state("fill", 8'hFF, 4'd0);
        drv(0, 0, 2'd0, 0, 0, 1, 3'd0, 1, 3'd2);
        step();
        drv(0, 0, 2'd0, 0, 0, 1, 3'd4, 1, 3'd6);
        step();
        state("baa", 8'hAA, 4'd4);

        // flush beats allocation and clear
        drv(1, 1, 2'd2, 0, 1, 1, 3'd1, 0, 3'd0);
        step();
        state("fl2", 8'h00, 4'd8);

        // async reset mid-allocation
        drv(1, 1, 2'd2, 0, 0, 0, 3'd0, 0, 3'd0);
        step();
        state("pre", 8'h03, 4'd6);
        #2;
        reset = 1'b1;
        #1;
        state("arst", 8'h00, 4'd8);
        step();
        state("arst2", 8'h00, 4'd8);
        reset = 1'b0;
        idle();
        chk("arst.alloc", 32'(allocatable), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
